bitwisexor_generate: RTL and testbench
======================================

Name: bitwisexor_generate

Overview:
- Registered, width-parameterised bitwise XOR of two operand words; each bit is produced by one generate-loop XOR cell.
- Computes f = a ^ b with one cycle of latency and a valid flag.
- Also registers the XOR-reduction parity of the result.
- Used as a difference or compare stage in datapaths, for example bit-mismatch masks between two words.

Parameters:
- WIDTH, 16, operand and result width in bits; legal range 1 to 64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  operands a/b are valid this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- f  output  WIDTH  registered bitwise XOR result
- out_valid  output  1  f/parity valid
- parity  output  1  XOR-reduction of f; 1 = odd number of set bits

Behaviour:
- All state updates on the rising edge of clk only.
- Reset: when rst_n=0 at a rising edge, f=0, out_valid=0, parity=0 (and diff_cnt=0 if present). Reset overrides in_valid in the same cycle.
- Datapath:
  - A generate loop over i=0..WIDTH-1 instantiates one XOR per bit: x[i] = a[i] ^ b[i].
  - No carries and no cross-bit interaction.
- Latency is exactly 1 cycle. If in_valid=1 at edge N (rst_n=1), then after edge N:
  - f = a ^ b
  - parity = ^(a ^ b)
  - out_valid = 1
- If in_valid=0 at an edge (rst_n=1):
  - out_valid goes to 0.
  - f and parity hold their previous values (no update, to save toggling).
- Back-to-back operation: in_valid may be high every cycle, giving full throughput of one result per cycle. There is no back-pressure.
- Identity cases:
  - a == b gives f=0, parity=0.
  - b = all ones gives f = ~a.
  - b = 0 gives f = a.
- Inputs are sampled only at clock edges. Glitches between edges have no effect.
- Reset asserted mid-stream: the in-flight result is discarded. out_valid is 0 on the cycle after reset, and the first valid output follows the first in_valid after rst_n returns high.

Optional Feature:
- Macro: BITWISEXOR_GENERATE_POPCNT_EN
- Defined:
  - Adds output port diff_cnt, width clog2(WIDTH+1) (5 bits for WIDTH=16).
  - diff_cnt is the registered population count of a ^ b, i.e. the Hamming distance between a and b.
  - It is implemented as a generate-built adder tree and updates under the same in_valid/hold rules and latency as f.
  - Reset value 0.
- Not defined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and a=16'hFFFF, b=16'h0000 -> f=16'h0000, out_valid=0, parity=0 throughout.
- Basic XOR: a=16'hAAAA, b=16'h00FF, in_valid=1 for one edge -> next cycle f=16'hAA55, out_valid=1, parity=0 (diff_cnt=8 if enabled).
- Second vector back-to-back: a=16'h0F0F, b=16'h3333 on the following edge -> f=16'h3C3C, parity=0, out_valid stays 1 (diff_cnt=8).
- Hold: drop in_valid while changing a=16'h0001, b=16'h0000 -> out_valid=0 and f holds 16'h3C3C; then raise in_valid -> f=16'h0001, parity=1 (diff_cnt=1).
- Identity/complement: a=b=16'h1234 -> f=0, parity=0; a=16'h1234, b=16'hFFFF -> f=16'hEDCB, parity=1 (diff_cnt=11).
- Reset mid-stream: assert rst_n=0 for one edge while in_valid=1 -> out_valid=0 and f=0 the next cycle; the first valid result appears one cycle after the next in_valid with rst_n=1.

Source files
------------

// File: rtl/bitwisexor_generate.sv
// bitwisexor_generate: registered bitwise XOR of two WIDTH-bit operands with
// a valid flag and the XOR-reduction parity of the result. One cycle latency.
//
// Optional build macro BITWISEXOR_GENERATE_POPCNT_EN adds diff_cnt, the
// registered Hamming distance between a and b, built as a generate adder tree.
// When the macro is undefined the port and its logic are absent.
module bitwisexor_generate #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic [WIDTH-1:0]             f,
  output logic                         out_valid,
  output logic                         parity
`ifdef BITWISEXOR_GENERATE_POPCNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0]   diff_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] f_d;
  logic [WIDTH-1:0] f_q;
  logic             parity_d;
  logic             parity_q;
  logic             valid_d;
  logic             valid_q;

  // One independent XOR cell per bit; no cross-bit interaction.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_xor
    assign x[i] = a[i] ^ b[i];
  end

`ifdef BITWISEXOR_GENERATE_POPCNT_EN
  // Tree depth and leaf count, padded up to a power of two.
  localparam int unsigned LEVELS = $clog2(WIDTH);
  localparam int unsigned LEAVES = 32'd1 << LEVELS;

  logic [CNT_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Binary adder tree: level 0 holds one bit per leaf, each level above
  // sums adjacent pairs; the single node at the top is the popcount.
  for (genvar l = 0; l <= int'(LEVELS); l++) begin : g_lvl
    localparam int unsigned N = LEAVES >> l;
    logic [CNT_W-1:0] s [N];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < int'(N); i++) begin : g_bit
        if (i < int'(WIDTH)) begin : g_used
          assign s[i] = CNT_W'(x[i]);
        end else begin : g_pad
          assign s[i] = '0;
        end
      end
    end else begin : g_add
      for (genvar k = 0; k < int'(N); k++) begin : g_node
        assign s[k] = g_lvl[l-1].s[2*k] + g_lvl[l-1].s[2*k+1];
      end
    end
  end

  assign cnt_sum = g_lvl[LEVELS].s[0];
`endif

  // Next-state: capture a new result on in_valid, otherwise hold data and drop valid.
  always_comb begin
    f_d      = f_q;
    parity_d = parity_q;
    valid_d  = 1'b0;
`ifdef BITWISEXOR_GENERATE_POPCNT_EN
    cnt_d    = cnt_q;
`endif
    if (in_valid) begin
      f_d      = x;
      parity_d = ^x;
      valid_d  = 1'b1;
`ifdef BITWISEXOR_GENERATE_POPCNT_EN
      cnt_d    = cnt_sum;
`endif
    end
  end

  // Output registers with synchronous active-low reset overriding in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_q      <= '0;
      parity_q <= 1'b0;
      valid_q  <= 1'b0;
`ifdef BITWISEXOR_GENERATE_POPCNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      f_q      <= f_d;
      parity_q <= parity_d;
      valid_q  <= valid_d;
`ifdef BITWISEXOR_GENERATE_POPCNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign f         = f_q;
  assign parity    = parity_q;
  assign out_valid = valid_q;
`ifdef BITWISEXOR_GENERATE_POPCNT_EN
  assign diff_cnt  = cnt_q;
`endif

endmodule

// File: tb/tb_bitwisexor_generate.sv
// Testbench for bitwisexor_generate: directed plan vectors followed by random
// traffic, each edge checked against a behavioural model of the block.
module tb_bitwisexor_generate;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] f;
  logic             out_valid;
  logic             parity;
`ifdef BITWISEXOR_GENERATE_POPCNT_EN
  logic [CNT_W-1:0] diff_cnt;
`endif

  int tests;
  int fails;

  // Model state: what the outputs should show after the latest edge.
  logic [WIDTH-1:0] exp_f;
  logic             exp_p;
  logic             exp_v;
  int               exp_cnt;

  bitwisexor_generate #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .f         (f),
    .out_valid (out_valid),
    .parity    (parity)
`ifdef BITWISEXOR_GENERATE_POPCNT_EN
    ,
    .diff_cnt  (diff_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of positions where the two words differ.
  function automatic int hamming(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int n;
    n = 0;
    for (int i = 0; i < int'(WIDTH); i++)
      if (x[i] != y[i]) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the
  // rising edge, and compare every output just after it.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    int d;
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
    d = hamming(av, bv);
    if (!r) begin
      exp_f = '0; exp_p = 1'b0; exp_v = 1'b0; exp_cnt = 0;
    end else if (v) begin
      exp_f = av ^ bv; exp_p = (d % 2) == 1; exp_v = 1'b1; exp_cnt = d;
    end else begin
      exp_v = 1'b0;
    end
    chk({tag, ".valid"},  64'(out_valid), 64'(exp_v));
    chk({tag, ".f"},      64'(f),         64'(exp_f));
    chk({tag, ".parity"}, 64'(parity),    64'(exp_p));
`ifdef BITWISEXOR_GENERATE_POPCNT_EN
    chk({tag, ".cnt"},    64'(diff_cnt),  64'(exp_cnt));
`endif
  endtask

  initial begin
    tests = 0; fails = 0;
    exp_f = '0; exp_p = 1'b0; exp_v = 1'b0; exp_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;

    // Reset overrides in_valid for two edges.
    step("rst0", 1'b0, 1'b1, 16'hFFFF, 16'h0000);
    step("rst1", 1'b0, 1'b1, 16'hFFFF, 16'h0000);
    chk("rst_f_lit", 64'(f), 64'h0);

    // Basic and back-to-back vectors.
    step("basic", 1'b1, 1'b1, 16'hAAAA, 16'h00FF);
    chk("basic_lit", 64'(f), 64'hAA55);
    step("b2b", 1'b1, 1'b1, 16'h0F0F, 16'h3333);
    chk("b2b_lit", 64'(f), 64'h3C3C);

    // Hold with changing operands, then resume.
    step("hold", 1'b1, 1'b0, 16'h0001, 16'h0000);
    chk("hold_lit", 64'(f), 64'h3C3C);
    step("resume", 1'b1, 1'b1, 16'h0001, 16'h0000);
    chk("resume_par", 64'(parity), 64'h1);

    // Identity cases.
    step("equal", 1'b1, 1'b1, 16'h1234, 16'h1234);
    step("compl", 1'b1, 1'b1, 16'h1234, 16'hFFFF);
    chk("compl_lit", 64'(f), 64'hEDCB);
    step("zero_b", 1'b1, 1'b1, 16'hBEEF, 16'h0000);
    step("all1", 1'b1, 1'b1, 16'hFFFF, 16'h0000);

    // Reset mid-stream, then idle, then first valid after release.
    step("mrst", 1'b0, 1'b1, 16'h5A5A, 16'hA5A5);
    step("idle", 1'b1, 1'b0, 16'h5A5A, 16'hA5A5);
    step("first", 1'b1, 1'b1, 16'h5A5A, 16'hA5A5);

    // Random traffic with sparse resets and gaps.
    for (int n = 0; n < 400; n++) begin
      logic r, v;
      r = ($urandom_range(0, 99) >= 3);
      v = ($urandom_range(0, 99) < 70);
      step("rand", r, v, WIDTH'($urandom), WIDTH'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
